// File: rtl/time_disp_scan.sv
// Six-digit multiplexed 7-segment driver for HH.MM.SS. It takes a once-per-frame
// snapshot of the binary time, splits each field to BCD, and scans the digits with a blinking separator.
module time_disp_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 83
) (
    input  logic       clk,
    input  logic       rset,
    input  logic       en,
    input  logic [7:0] sec,
    input  logic [7:0] min,
    input  logic [7:0] hour,
    output logic [7:0] seg,
    output logic [5:0] dig_sel,
    output logic       frame_done
);

    localparam int TICK_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(SCAN_DIV - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);
    localparam logic [2:0]         IDX_LAST   = 3'd5;
    localparam logic [7:0]         SEG_BLANK  = 8'hFF;
    localparam logic [7:0]         SEG_DASH   = 8'hBF;
    localparam logic [5:0]         DIG_NONE   = 6'h3F;

    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         snap_hour_q, snap_hour_d;
    logic [7:0]         snap_min_q, snap_min_d;
    logic [7:0]         snap_sec_q, snap_sec_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               blink_q, blink_d;
    logic               tick_q, tick_d;
    logic [7:0]         seg_q, seg_d;
    logic [5:0]         dig_sel_q, dig_sel_d;
    logic               frame_done_q, frame_done_d;

    logic       tick;
    logic [7:0] field;
    logic [7:0] tens;
    logic [7:0] units;
    logic [3:0] digit;
    logic [7:0] code;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] c;
        case (d)
            4'd0:    c = 8'hC0;
            4'd1:    c = 8'hF9;
            4'd2:    c = 8'hA4;
            4'd3:    c = 8'hB0;
            4'd4:    c = 8'h99;
            4'd5:    c = 8'h92;
            4'd6:    c = 8'h82;
            4'd7:    c = 8'hF8;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h90;
            default: c = SEG_DASH;
        endcase
        return c;
    endfunction

    // Scan timing, frame snapshot and blink phase; everything freezes while en=0.
    always_comb begin
        tick         = en && (tick_cnt_q == TICK_LAST);
        tick_cnt_d   = tick_cnt_q;
        idx_d        = idx_q;
        snap_hour_d  = snap_hour_q;
        snap_min_d   = snap_min_q;
        snap_sec_d   = snap_sec_q;
        frame_cnt_d  = frame_cnt_q;
        blink_d      = blink_q;
        tick_d       = tick;

        if (en) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
        end

        if (tick) begin
            if (idx_q == IDX_LAST) begin
                idx_d       = 3'd0;
                snap_hour_d = hour;
                snap_min_d  = min;
                snap_sec_d  = sec;
                if (frame_cnt_q == FRAME_LAST) begin
                    frame_cnt_d = '0;
                    blink_d     = ~blink_q;
                end else begin
                    frame_cnt_d = frame_cnt_q + FRAME_W'(1);
                end
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
    end

    // Pin decode from the current digit slot and the frozen snapshot.
    always_comb begin
        case (idx_q)
            3'd0, 3'd1: field = snap_hour_q;
            3'd2, 3'd3: field = snap_min_q;
            default:    field = snap_sec_q;
        endcase

        tens  = field / 8'd10;
        units = field % 8'd10;
        digit = idx_q[0] ? units[3:0] : tens[3:0];
        code  = (field >= 8'd100) ? SEG_DASH : seg_code(digit);

        // Separator dots sit after the hour and minute units digits.
        if (blink_q && (idx_q == 3'd1 || idx_q == 3'd3)) begin
            code[7] = 1'b0;
        end

        seg_d        = SEG_BLANK;
        dig_sel_d    = DIG_NONE;
        frame_done_d = 1'b0;
        if (en) begin
            seg_d        = code;
            dig_sel_d    = ~(6'b000001 << idx_q);
            frame_done_d = tick_q && (idx_q == 3'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rset) begin
            tick_cnt_q   <= '0;
            idx_q        <= IDX_LAST;
            snap_hour_q  <= 8'd0;
            snap_min_q   <= 8'd0;
            snap_sec_q   <= 8'd0;
            frame_cnt_q  <= '0;
            blink_q      <= 1'b0;
            tick_q       <= 1'b0;
            seg_q        <= SEG_BLANK;
            dig_sel_q    <= DIG_NONE;
            frame_done_q <= 1'b0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            idx_q        <= idx_d;
            snap_hour_q  <= snap_hour_d;
            snap_min_q   <= snap_min_d;
            snap_sec_q   <= snap_sec_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_q      <= blink_d;
            tick_q       <= tick_d;
            seg_q        <= seg_d;
            dig_sel_q    <= dig_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dig_sel    = dig_sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_time_disp_scan.sv
// Bench for time_disp_scan: directed scenarios with literal expectations plus a
// randomized run, all outputs compared every cycle against a behavioural display model.
module tb_time_disp_scan;

    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;

    logic       clk  = 1'b0;
    logic       rset = 1'b1;
    logic       en   = 1'b0;
    logic [7:0] sec  = 8'd0;
    logic [7:0] min  = 8'd0;
    logic [7:0] hour = 8'd0;
    logic [7:0] seg;
    logic [5:0] dig_sel;
    logic       frame_done;

    always #5 clk = ~clk;

    time_disp_scan #(
        .SCAN_DIV    (SCAN_DIV),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk       (clk),
        .rset      (rset),
        .en        (en),
        .sec       (sec),
        .min       (min),
        .hour      (hour),
        .seg       (seg),
        .dig_sel   (dig_sel),
        .frame_done(frame_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] codes [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit         m_valid = 0;
    int         m_cnt;        // enabled cycles since reset
    int         m_slot;       // digit currently scanned
    int         m_frames;     // snapshots taken since reset
    bit         m_prev_tick;
    bit         m_tick;
    logic [7:0] m_snap [3];   // hour, min, sec
    logic [7:0] exp_seg;
    logic [5:0] exp_dig;
    logic       exp_fd;

    function automatic logic [7:0] model_digit(input int slot, input logic [7:0] v, input bit blink);
        logic [7:0] c;
        int         d;
        d = (slot % 2 == 1) ? int'(v) % 10 : int'(v) / 10;
        if (v >= 8'd100) c = 8'hBF;
        else             c = codes[d];
        if (blink && (slot == 1 || slot == 3)) c[7] = 1'b0;
        return c;
    endfunction

    always @(posedge clk) begin
        m_valid = 1;
        if (rset) begin
            exp_seg     = 8'hFF;
            exp_dig     = 6'h3F;
            exp_fd      = 1'b0;
            m_cnt       = 0;
            m_slot      = 5;
            m_frames    = 0;
            m_prev_tick = 0;
            m_snap[0]   = 8'd0;
            m_snap[1]   = 8'd0;
            m_snap[2]   = 8'd0;
        end else begin
            m_tick = en && (m_cnt % SCAN_DIV == SCAN_DIV - 1);
            if (en) begin
                exp_seg = model_digit(m_slot, m_snap[m_slot / 2], ((m_frames / BLINK_FRAMES) % 2) == 1);
                exp_dig = ~(6'b000001 << m_slot);
                exp_fd  = m_prev_tick && (m_slot == 0);
                m_cnt++;
            end else begin
                exp_seg = 8'hFF;
                exp_dig = 6'h3F;
                exp_fd  = 1'b0;
            end
            if (m_tick) begin
                if (m_slot == 5) begin
                    m_slot    = 0;
                    m_snap[0] = hour;
                    m_snap[1] = min;
                    m_snap[2] = sec;
                    m_frames++;
                end else begin
                    m_slot++;
                end
            end
            m_prev_tick = m_tick;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_seg", 32'(seg), 32'(exp_seg));
            check("model_dig_sel", 32'(dig_sel), 32'(exp_dig));
            check("model_frame_done", 32'(frame_done), 32'(exp_fd));
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic wait_frame(output int waited);
        waited = -1;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                waited = i;
                return;
            end
        end
        check("frame_done_timeout", 32'd0, 32'd1);
    endtask

    logic [7:0] t1_seg [6] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82};
    logic [5:0] t1_dig [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    logic [7:0] t3_seg [6] = '{8'hBF, 8'hBF, 8'hC0, 8'hC0, 8'hC0, 8'h90};
    bit         t4_dp  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int w;

        // 1: reset, then first frame of 12:34:56
        repeat (3) @(negedge clk);
        check("reset_seg", 32'(seg), 32'hFF);
        check("reset_dig_sel", 32'(dig_sel), 32'h3F);
        check("reset_frame_done", 32'(frame_done), 32'd0);
        rset = 1'b0;
        en   = 1'b1;
        hour = 8'd12;
        min  = 8'd34;
        sec  = 8'd56;
        wait_frame(w);
        check("first_frame_latency", 32'(w), 32'd5);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) repeat (SCAN_DIV) @(negedge clk);
            check("t1_seg", 32'(seg), 32'(t1_seg[k]));
            check("t1_dig_sel", 32'(dig_sel), 32'(t1_dig[k]));
        end

        // 2: change seconds mid-frame; no tearing
        wait_frame(w);
        repeat (2 * SCAN_DIV) @(negedge clk);
        sec = 8'd57;
        repeat (3 * SCAN_DIV) @(negedge clk);
        check("t2_old_sec_units", 32'(seg), 32'h82);
        wait_frame(w);
        repeat (5 * SCAN_DIV) @(negedge clk);
        check("t2_new_sec_units", 32'(seg), 32'hF8);

        // 3: overflowing hour shows dashes, zero padding elsewhere
        hour = 8'd123;
        min  = 8'd0;
        sec  = 8'd9;
        wait_frame(w);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) repeat (SCAN_DIV) @(negedge clk);
            check("t3_seg", 32'(seg), 32'(t3_seg[k]));
        end

        // 4: separator blink over four frames
        hour = 8'd23;
        min  = 8'd59;
        sec  = 8'd58;
        for (int f = 0; f < 4; f++) begin
            wait_frame(w);
            check("t4_dp_idx0", 32'(seg[7]), 32'd1);
            repeat (SCAN_DIV) @(negedge clk);
            check("t4_dp_idx1", 32'(seg[7]), 32'(t4_dp[f]));
        end

        // 5: disable in the middle of idx3
        wait_frame(w);
        repeat (3 * SCAN_DIV + 1) @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_blank_seg", 32'(seg), 32'hFF);
            check("t5_blank_dig", 32'(dig_sel), 32'h3F);
            check("t5_no_frame", 32'(frame_done), 32'd0);
        end
        en = 1'b1;
        @(negedge clk);
        check("t5_resume_idx3", 32'(dig_sel), 32'h37);

        // 6: reset pulse at idx4
        hour = 8'd7;
        min  = 8'd45;
        sec  = 8'd30;
        wait_frame(w);
        repeat (4 * SCAN_DIV) @(negedge clk);
        rset = 1'b1;
        @(negedge clk);
        check("t6_reset_seg", 32'(seg), 32'hFF);
        check("t6_reset_dig", 32'(dig_sel), 32'h3F);
        rset = 1'b0;
        wait_frame(w);
        check("t6_frame_latency", 32'(w), 32'd5);
        check("t6_idx0_seg", 32'(seg), 32'hC0);
        check("t6_idx0_dig", 32'(dig_sel), 32'h3E);

        // Randomized run: input changes, enable gaps, occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 19) == 0) en = ~en;
            if ($urandom_range(0, 29) == 0) begin
                hour = 8'($urandom_range(0, 130));
                min  = 8'($urandom_range(0, 110));
                sec  = 8'($urandom_range(0, 105));
            end
        end
        rset = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
